// File: rtl/joy_input_conditioner.sv
// Two-player joystick/fire conditioner: two-flop sync, per-bit debounce, opposing-direction
// suppression and registered SWCHA-format outputs for the PIA/TIA.
module joy_input_conditioner #(
  parameter int unsigned CNT_W        = 18,
  parameter int unsigned DEBOUNCE_CNT = 250000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [4:0] p0_raw,
  input  logic [4:0] p1_raw,
  output logic [7:0] buttons,
  output logic [1:0] fire_n,
  output logic       changed,
  output logic       ready
);

  localparam int unsigned NBITS = 10;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

  logic [NBITS-1:0] sync1;
  logic [NBITS-1:0] sync2;
  logic [NBITS-1:0] stable;
  logic [CNT_W-1:0] cnt [NBITS];
  logic [CNT_W-1:0] rdy_cnt;
  logic [7:0]       buttons_prev;
  logic [1:0]       fire_prev;
  logic [3:0]       p0_dir;
  logic [3:0]       p1_dir;
  logic [7:0]       buttons_next;
  logic [1:0]       fire_next;

  // Bits [4:0] are player 0, [9:5] player 1; layout [4]=fire [3]=R [2]=L [1]=D [0]=U.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {p1_raw, p0_raw};
      sync2 <= sync1;
    end
  end

  // Per-bit debounce: any mismatch run shorter than DEBOUNCE_CNT is discarded entirely.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stable <= '0;
      for (int i = 0; i < NBITS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NBITS; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // A pressed opposing pair reads as neither pressed; releases as soon as one side drops.
  function automatic logic [3:0] opp_filter(input logic [3:0] d);
    logic [3:0] f;
    f = d;
    if (d[0] && d[1]) f[1:0] = 2'b00;
    if (d[2] && d[3]) f[3:2] = 2'b00;
    return f;
  endfunction

  always_comb begin
    p0_dir       = opp_filter(stable[3:0]);
    p1_dir       = opp_filter(stable[8:5]);
    buttons_next = ~{p0_dir, p1_dir};
    fire_next    = ~{stable[9], stable[4]};
  end

  // Output register; changed flags a value update one cycle after it lands.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      buttons      <= 8'hFF;
      fire_n       <= 2'b11;
      buttons_prev <= 8'hFF;
      fire_prev    <= 2'b11;
      changed      <= 1'b0;
    end else begin
      buttons      <= buttons_next;
      fire_n       <= fire_next;
      buttons_prev <= buttons;
      fire_prev    <= fire_n;
      changed      <= (buttons != buttons_prev) || (fire_n != fire_prev);
    end
  end

  // Startup window: saturating counter, ready sticks high until reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rdy_cnt <= '0;
      ready   <= 1'b0;
    end else begin
      if (rdy_cnt != CNT_LAST) begin
        rdy_cnt <= rdy_cnt + CNT_W'(1);
      end
      if (rdy_cnt == CNT_LAST) begin
        ready <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_joy_input_conditioner.sv
// Bench for joy_input_conditioner: directed scenarios plus randomized inputs checked against
// a sliding-window "held for DEBOUNCE_CNT samples" reference model.
module tb_joy_input_conditioner;

  localparam int unsigned DC  = 4;
  localparam int unsigned CW  = 3;
  localparam int          LAT = int'(DC) + 2;

  logic       clk_i  = 1'b0;
  logic       rst_i  = 1'b0;
  logic [4:0] p0_raw = '0;
  logic [4:0] p1_raw = '0;
  logic [7:0] buttons;
  logic [1:0] fire_n;
  logic       changed;
  logic       ready;

  int vectors = 0;
  int errors  = 0;

  joy_input_conditioner #(.CNT_W(CW), .DEBOUNCE_CNT(DC)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .p0_raw  (p0_raw),
    .p1_raw  (p1_raw),
    .buttons (buttons),
    .fire_n  (fire_n),
    .changed (changed),
    .ready   (ready)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: a level is accepted once it has been the synchronised sample for DC
  // consecutive edges; outputs trail acceptance by one edge, changed by one more.
  logic [9:0] hist [$];
  logic [9:0] m_stable;
  logic [7:0] m_btn, m_btn_prev;
  logic [1:0] m_fire, m_fire_prev;
  logic       m_changed, m_ready;
  int         m_edges;

  function automatic logic [3:0] dir_view(input logic [3:0] d);
    logic up, dn, lf, rt;
    up = d[0] & ~d[1];
    dn = d[1] & ~d[0];
    lf = d[2] & ~d[3];
    rt = d[3] & ~d[2];
    return {rt, lf, dn, up};
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < LAT; i++) hist.push_front(10'h000);
    m_stable    = '0;
    m_btn       = 8'hFF;
    m_btn_prev  = 8'hFF;
    m_fire      = 2'b11;
    m_fire_prev = 2'b11;
    m_changed   = 1'b0;
    m_ready     = 1'b0;
    m_edges     = 0;
  endtask

  task automatic model_step();
    logic all1, all0;
    hist.push_front({p1_raw, p0_raw});
    if (hist.size() > LAT) void'(hist.pop_back());
    m_changed   = ({m_btn, m_fire} != {m_btn_prev, m_fire_prev});
    m_btn_prev  = m_btn;
    m_fire_prev = m_fire;
    m_btn       = ~{dir_view(m_stable[3:0]), dir_view(m_stable[8:5])};
    m_fire      = ~{m_stable[9], m_stable[4]};
    for (int b = 0; b < 10; b++) begin
      all1 = 1'b1;
      all0 = 1'b1;
      for (int d = 2; d < LAT; d++) begin
        if (hist[d][b]) all0 = 1'b0;
        else            all1 = 1'b0;
      end
      if (all1)      m_stable[b] = 1'b1;
      else if (all0) m_stable[b] = 1'b0;
    end
    m_edges = m_edges + 1;
    m_ready = (m_edges >= int'(DC));
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk_i);
      if (!rst_i) model_reset();
      else        model_step();
    end
  end

  task automatic test_reset();
    rst_i  = 1'b0;
    p0_raw = '0;
    p1_raw = '0;
    repeat (3) @(negedge clk_i);
    vectors++;
    if ({buttons, fire_n, changed, ready} !== {8'hFF, 2'b11, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_hold: got %h/%b/%b/%b want ff/11/0/0", buttons, fire_n, changed, ready);
    end
    rst_i = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk_i);
      vectors++;
      if (ready !== 1'(j >= int'(DC))) begin
        errors++;
        $display("FAIL reset_ready edge %0d: got %b want %b", j, ready, j >= int'(DC));
      end
      vectors++;
      if (buttons !== 8'hFF || fire_n !== 2'b11 || changed !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle edge %0d: got %h/%b/%b want ff/11/0", j, buttons, fire_n, changed);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [7:0] exp_b;
    for (int ph = 0; ph < 2; ph++) begin
      p0_raw = (ph == 0) ? 5'b00001 : 5'b00000;
      for (int j = 0; j < 10; j++) begin
        @(negedge clk_i);
        exp_b = ((j >= LAT) == (ph == 0)) ? 8'hEF : 8'hFF;
        vectors++;
        if (buttons !== exp_b || changed !== 1'(j == LAT + 1)) begin
          errors++;
          $display("FAIL clean_press ph%0d edge %0d: got %h/%b want %h/%b", ph, j, buttons, changed,
                   exp_b, j == LAT + 1);
        end
      end
    end
  endtask

  task automatic test_glitch();
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 4; c++) begin
        p1_raw = (c < 3) ? 5'b10000 : 5'b00000;
        @(negedge clk_i);
        vectors++;
        if (fire_n !== 2'b11 || changed !== 1'b0 || buttons !== 8'hFF) begin
          errors++;
          $display("FAIL glitch r%0d c%0d: got %b/%b/%h want 11/0/ff", r, c, fire_n, changed, buttons);
        end
      end
    end
    repeat (LAT + 2) begin
      @(negedge clk_i);
      vectors++;
      if (fire_n !== 2'b11 || changed !== 1'b0) begin
        errors++;
        $display("FAIL glitch_tail: got %b/%b want 11/0", fire_n, changed);
      end
    end
  endtask

  task automatic test_opposing();
    logic [7:0] exp_b;
    p0_raw = 5'b01100;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk_i);
      vectors++;
      if (buttons !== 8'hFF || changed !== 1'b0) begin
        errors++;
        $display("FAIL opposing_both edge %0d: got %h/%b want ff/0", j, buttons, changed);
      end
    end
    p0_raw = 5'b00100;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk_i);
      exp_b = (j >= LAT) ? 8'hBF : 8'hFF;
      vectors++;
      if (buttons !== exp_b || changed !== 1'(j == LAT + 1)) begin
        errors++;
        $display("FAIL opposing_release edge %0d: got %h/%b want %h/%b", j, buttons, changed,
                 exp_b, j == LAT + 1);
      end
    end
    p0_raw = 5'b00000;
    repeat (LAT + 3) @(negedge clk_i);
    vectors++;
    if (buttons !== 8'hFF) begin
      errors++;
      $display("FAIL opposing_idle: got %h want ff", buttons);
    end
  endtask

  task automatic test_simultaneous();
    logic pressed;
    p0_raw = 5'b00001;
    p1_raw = 5'b10000;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk_i);
      pressed = (j >= LAT);
      vectors++;
      if (buttons !== (pressed ? 8'hEF : 8'hFF) || fire_n !== (pressed ? 2'b01 : 2'b11) ||
          changed !== 1'(j == LAT + 1)) begin
        errors++;
        $display("FAIL simultaneous edge %0d: got %h/%b/%b pressed=%b", j, buttons, fire_n,
                 changed, pressed);
      end
    end
    p0_raw = '0;
    p1_raw = '0;
    repeat (LAT + 3) @(negedge clk_i);
  endtask

  task automatic test_mid_reset();
    logic pressed;
    p1_raw = 5'b10000;
    repeat (LAT + 3) @(negedge clk_i);
    vectors++;
    if (fire_n !== 2'b01) begin
      errors++;
      $display("FAIL mid_reset_pre: got %b want 01", fire_n);
    end
    p0_raw = 5'b00001;
    repeat (4) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    vectors++;
    if ({buttons, fire_n, changed, ready} !== {8'hFF, 2'b11, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset_now: got %h/%b/%b/%b want ff/11/0/0", buttons, fire_n, changed, ready);
    end
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk_i);
      pressed = (j >= LAT + 1);
      vectors++;
      if (buttons !== (pressed ? 8'hEF : 8'hFF) || fire_n !== (pressed ? 2'b01 : 2'b11) ||
          changed !== 1'(j == LAT + 2) || ready !== 1'(j >= int'(DC))) begin
        errors++;
        $display("FAIL mid_reset_after edge %0d: got %h/%b/%b/%b", j, buttons, fire_n, changed, ready);
      end
    end
    p0_raw = '0;
    p1_raw = '0;
    repeat (LAT + 3) @(negedge clk_i);
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (hold == 0) begin
        {p1_raw, p0_raw} = {p1_raw, p0_raw} ^ (10'($urandom) & 10'($urandom));
        hold = $urandom_range(1, 2 * DC + 1);
      end
      hold--;
      @(negedge clk_i);
      vectors++;
      if (buttons !== m_btn || fire_n !== m_fire || changed !== m_changed || ready !== m_ready) begin
        errors++;
        $display("FAIL random cyc %0d: got %h/%b/%b/%b want %h/%b/%b/%b", cyc, buttons, fire_n,
                 changed, ready, m_btn, m_fire, m_changed, m_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_opposing();
    test_simultaneous();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
